// File: rtl/rsc_step_ctrl.sv
// rsc_step_ctrl: control front-end for the rotating-square display.
// Each raw switch or button goes through a two-flop synchronizer and then a
// debounce FSM. The debounced run level gates a rate counter that emits a
// one-cycle step pulse every TICK_DIV cycles. The debounced direction level
// goes straight out as cw.
// Optional feature: define RSC_SINGLE_STEP_EN to let a debounced btn_step press
// issue a single step while the display is stopped.

// Debounce FSM. A new level is accepted only after DB_CYCLES consecutive
// synchronized cycles at that level. 'fall' flags that 'level' drops on the
// next edge, so the rate logic can avoid a step on the cycle run goes low.
module rsc_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic fall
);

   typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} db_state_t;

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES);
   localparam logic [CW-1:0] ONE     = CW'(1);

   db_state_t      state;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_inc;

   // Saturating increment so the counter can never wrap back to a small value
   assign cnt_inc = (cnt == DB_LAST) ? cnt : cnt + ONE;

   // Look-ahead of the HIGH-to-LOW acceptance, matching the FSM transitions below
   assign fall = ((state == WAIT_LO) && !din && (cnt_inc == DB_LAST)) ||
                 ((state == HIGH) && !din && (DB_CYCLES == 1));

   // Debounce state machine with the accepted level as a registered output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= LOW;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         case (state)
            LOW: begin
               if (din) begin
                  if (DB_CYCLES == 1) begin
                     state <= HIGH;
                     level <= 1'b1;
                     cnt   <= '0;
                  end else begin
                     state <= WAIT_HI;
                     cnt   <= ONE;
                  end
               end
            end
            WAIT_HI: begin
               if (!din) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (cnt_inc == DB_LAST) begin
                  state <= HIGH;
                  level <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt_inc;
               end
            end
            HIGH: begin
               if (!din) begin
                  if (DB_CYCLES == 1) begin
                     state <= LOW;
                     level <= 1'b0;
                     cnt   <= '0;
                  end else begin
                     state <= WAIT_LO;
                     cnt   <= ONE;
                  end
               end
            end
            WAIT_LO: begin
               if (din) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt_inc == DB_LAST) begin
                  state <= LOW;
                  level <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt_inc;
               end
            end
            default: begin
               state <= LOW;
               cnt   <= '0;
               level <= 1'b0;
            end
         endcase
      end
   end

endmodule

module rsc_step_ctrl #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_en,
   input  logic sw_cw,
   input  logic btn_step,
   output logic run,
   output logic cw,
   output logic step
);

   localparam int RW = $clog2(TICK_DIV);
   localparam logic [RW-1:0] RATE_LAST = RW'(TICK_DIV - 1);
   localparam logic [RW-1:0] RATE_ONE  = RW'(1);

   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic          run_fall;
   logic          cw_fall_unused;
   logic [RW-1:0] rate_cnt;
   logic          rate_hit;
   logic          single_hit;

   // Two-flop synchronizers for the run and direction switches
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {sw_cw, sw_en};
         sync2 <= sync1;
      end
   end

   rsc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_en (
      .clk   (clk),
      .reset (reset),
      .din   (sync2[0]),
      .level (run),
      .fall  (run_fall)
   );

   // The direction level is the FSM's own output; the rotator samples it on step
   rsc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_cw (
      .clk   (clk),
      .reset (reset),
      .din   (sync2[1]),
      .level (cw),
      .fall  (cw_fall_unused)
   );

   // Rate counter runs only while run is high, so each resume starts a full period
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rate_cnt <= '0;
      end else if (!run || (rate_cnt == RATE_LAST)) begin
         rate_cnt <= '0;
      end else begin
         rate_cnt <= rate_cnt + RATE_ONE;
      end
   end

   assign rate_hit = run && !run_fall && (rate_cnt == RATE_LAST);

`ifdef RSC_SINGLE_STEP_EN
   logic       btn_sync1;
   logic       btn_sync2;
   logic       btn_level;
   logic       btn_prev;
   logic       btn_fall_unused;

   // Synchronizer and previous-level register for the single-step button
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_sync1 <= 1'b0;
         btn_sync2 <= 1'b0;
         btn_prev  <= 1'b0;
      end else begin
         btn_sync1 <= btn_step;
         btn_sync2 <= btn_sync1;
         btn_prev  <= btn_level;
      end
   end

   rsc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_btn (
      .clk   (clk),
      .reset (reset),
      .din   (btn_sync2),
      .level (btn_level),
      .fall  (btn_fall_unused)
   );

   assign single_hit = btn_level && !btn_prev && !run;
`else
   logic unused_btn;
   assign unused_btn = btn_step;
   assign single_hit = 1'b0;
`endif

   // Registered step pulse merging the rate and single-step sources
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step <= 1'b0;
      end else begin
         step <= rate_hit || single_hit;
      end
   end

endmodule

// File: tb/tb_rsc_step_ctrl.sv
// Testbench for rsc_step_ctrl with TICK_DIV=4, DB_CYCLES=3.
// A cycle-level reference model predicts {run, cw, step} for every clock and
// pushes it to a scoreboard queue, which is popped and compared after the edge.
module tb_rsc_step_ctrl;

   localparam int TD = 4;
   localparam int DB = 3;

   logic clk = 1'b0;
   logic reset;
   logic sw_en;
   logic sw_cw;
   logic btn_step;
   logic run;
   logic cw;
   logic step;

   int vectors = 0;
   int miscompares = 0;

   logic [2:0] exp_q[$];

   logic [2:0] m_s1;
   logic [2:0] m_s2;
   logic [2:0] m_lvl;
   int         m_cnt [3];
   int         m_k;
   logic       m_step;
   logic       m_btn_prev;

   always #5 clk = ~clk;

   rsc_step_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
      .clk      (clk),
      .reset    (reset),
      .sw_en    (sw_en),
      .sw_cw    (sw_cw),
      .btn_step (btn_step),
      .run      (run),
      .cw       (cw),
      .step     (step)
   );

   task automatic checkOutput(input string tag, input logic [2:0] got, input logic [2:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: run/cw/step got %b, expected %b at %0t", tag, got, want, $time);
      end
   endtask

   task automatic modelReset();
      m_s1 = '0;
      m_s2 = '0;
      m_lvl = '0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_k = 0;
      m_step = 1'b0;
      m_btn_prev = 1'b0;
   endtask

   // One clock edge of the reference model; raw = {btn, cw, en}
   task automatic modelEdge(input logic [2:0] raw);
      logic old_run;
      logic old_btn;
      logic rs;
      logic ss;
      old_run = m_lvl[0];
      old_btn = m_lvl[2];
      for (int i = 0; i < 3; i++) begin
         if (m_s2[i] != m_lvl[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == DB) begin
               m_lvl[i] = ~m_lvl[i];
               m_cnt[i] = 0;
            end
         end else begin
            m_cnt[i] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      if (m_lvl[0] && old_run) begin
         m_k++;
         rs = ((m_k % TD) == 0);
      end else begin
         m_k = 0;
         rs = 1'b0;
      end
      ss = 1'b0;
`ifdef RSC_SINGLE_STEP_EN
      ss = old_btn && !m_btn_prev && !old_run;
`endif
      m_btn_prev = old_btn;
      m_step = rs || ss;
   endtask

   // Drive raw inputs, predict the next edge, then compare after that edge
   task automatic applyStimulus(input string tag, input logic e, input logic c, input logic b);
      sw_en = e;
      sw_cw = c;
      btn_step = b;
      modelEdge({b, c, e});
      exp_q.push_back({m_lvl[0], m_lvl[1], m_step});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL %s: scoreboard empty, got %b expected a queued value", tag, {run, cw, step});
      end else begin
         checkOutput(tag, {run, cw, step}, exp_q.pop_front());
      end
   endtask

   initial begin
      logic e;
      logic c;
      logic b;
      reset = 1'b1;
      sw_en = 1'b0;
      sw_cw = 1'b0;
      btn_step = 1'b0;
      modelReset();
      #1;
      checkOutput("reset_hold", {run, cw, step}, 3'b000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_release", {run, cw, step}, 3'b000);

      repeat (20) applyStimulus("idle", 1'b0, 1'b0, 1'b0);
      repeat (20) applyStimulus("run_up", 1'b1, 1'b0, 1'b0);
      repeat (10) applyStimulus("cw_while_run", 1'b1, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a cycle with run and cw high
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async_reset", {run, cw, step}, 3'b000);
      modelReset();
      sw_en = 1'b0;
      sw_cw = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset_held", {run, cw, step}, 3'b000);
      reset = 1'b0;

      repeat (12) applyStimulus("rerun", 1'b1, 1'b0, 1'b0);
      applyStimulus("bounce", 1'b1, 1'b1, 1'b0);
      applyStimulus("bounce", 1'b1, 1'b0, 1'b0);
      applyStimulus("bounce", 1'b1, 1'b1, 1'b0);
      applyStimulus("bounce", 1'b1, 1'b0, 1'b0);
      repeat (10) applyStimulus("cw_hold", 1'b1, 1'b1, 1'b0);

      for (int p = 0; p < 4; p++) begin
         repeat (p) applyStimulus("phase_shift", 1'b1, 1'b1, 1'b0);
         repeat (10) applyStimulus("run_drop", 1'b0, 1'b1, 1'b0);
         repeat (14) applyStimulus("run_resume", 1'b1, 1'b1, 1'b0);
      end

      repeat (10) applyStimulus("stop", 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 2; n++) begin
         repeat (10) applyStimulus("btn_press", 1'b0, 1'b0, 1'b1);
         repeat (10) applyStimulus("btn_release", 1'b0, 1'b0, 1'b0);
      end
      repeat (10) applyStimulus("run_for_btn", 1'b1, 1'b0, 1'b0);
      repeat (10) applyStimulus("btn_while_run", 1'b1, 1'b0, 1'b1);
      repeat (10) applyStimulus("btn_release_run", 1'b1, 1'b0, 1'b0);
      repeat (10) applyStimulus("stop2", 1'b0, 1'b0, 1'b0);
      repeat (30) applyStimulus("btn_toggle", 1'b0, 1'b0, 1'($urandom_range(0, 1)));

      e = 1'b0;
      c = 1'b0;
      b = 1'b0;
      repeat (400) begin
         if ($urandom_range(0, 7) == 0) e = ~e;
         if ($urandom_range(0, 7) == 0) c = ~c;
         if ($urandom_range(0, 5) == 0) b = ~b;
         applyStimulus("random", e, c, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
